reaction_ctrl: RTL and testbench
================================

# reaction_ctrl

Reaction-timer control stage that sits directly downstream of the 12-bit LFSR. On a start press it captures the current pseudo-random value, waits a random number of millisecond ticks, then lights the stimulus LED. It then counts milliseconds until the player presses the react button and holds the result for the display stage. Early presses and timeouts are flagged.

## Interface
Parameters:
- `N`, 12, width of the random input (LFSR width).
- `DELAY_BASE`, 1000, fixed minimum wait in ticks, added to the random value.
- `MAX_MS`, 9999, reaction count saturation / timeout value (4-digit display limit).
- `CW`, 14, width of `time_ms`; must satisfy 2^CW > `MAX_MS`.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `tick_ms`  in  1  one-cycle enable pulse, once per millisecond.
- `random`  in  N  current LFSR value.
- `start`  in  1  start button level, already synchronized and debounced.
- `react`  in  1  react button level, already synchronized and debounced.
- `led`  out  1  stimulus LED; high only in ARMED.
- `time_ms`  out  CW  measured reaction time in ticks.
- `done`  out  1  high in DONE (valid result or timeout).
- `too_early`  out  1  high in EARLY.
- `timeout`  out  1  high in DONE when the count reached `MAX_MS`.
- `busy`  out  1  high in WAIT or ARMED.

## Operation
- Rising edges of `start` and `react` are detected internally. Edge-detect history flops reset to 1, so a button held through reset release produces no edge.
- The block has five states: IDLE, WAIT, ARMED, DONE, EARLY. All outputs are registered or decoded from the registered state.
- IDLE, DONE, EARLY + start edge -> WAIT:
  - load `dly = DELAY_BASE + random`; the delay counter is 13 bits at default parameters (max 5095);
  - clear `time_ms`, `timeout`.
- WAIT:
  - each `tick_ms` decrements `dly`;
  - a tick with `dly == 1` -> ARMED;
  - if loaded `dly == 0`, go to ARMED on the next cycle without waiting for a tick;
  - react edge -> EARLY; this takes priority over a same-cycle tick.
- ARMED:
  - entry clears `time_ms` to 0; each tick increments it;
  - react edge -> DONE, `time_ms` frozen; a react edge and tick in the same cycle: react wins and the tick is not counted;
  - a tick that makes `time_ms == MAX_MS` -> DONE with `timeout = 1`; `time_ms` never exceeds `MAX_MS`.
- DONE and EARLY hold all outputs until the next start edge.
- Start edges in WAIT or ARMED are ignored. React edges in IDLE, DONE or EARLY are ignored.
- Reset asserted at any time -> IDLE immediately, mid-operation included. Reset values: all outputs 0, `time_ms = 0`, `dly = 0`.

## Timing
- Start edge detected in cycle t -> state WAIT and `busy = 1` at t+1. `random` is sampled in cycle t.
- WAIT lasts exactly `DELAY_BASE + random` ticks. `led` rises the cycle after the final tick.
- React edge in cycle t -> `led` falls and `done = 1` at t+1, `time_ms` stable from t+1.
- Edge detection adds one cycle: a button level rising at cycle t registers as an edge in cycle t+1.
- `time_ms` = number of ticks strictly between `led` rising and the react edge, saturating at `MAX_MS`.

## Structure
- Shared package/header `rt_pkg` holds:
  - state encoding constants (IDLE=0, WAIT=1, ARMED=2, DONE=3, EARLY=4, 3 bits);
  - `DELAY_BASE` and `MAX_MS` defaults, reused by the display stage.
- One sub-module, `rise_det`: a parameterized-reset-value rising-edge detector, instantiated twice (`start`, `react`).
- The remainder (FSM, delay down-counter, reaction up-counter) lives in `reaction_ctrl`.

## Test plan
- `DELAY_BASE=2`, `random=5`, start edge -> `busy=1` next cycle; `led` rises after exactly 7 ticks. Press react after 3 more ticks -> `done=1`, `time_ms=3`, `led=0`.
- React edge during WAIT (after 2 of 7 ticks) -> `too_early=1`, `led` never rises, `busy=0`. A later start edge clears `too_early` and restarts.
- ARMED with no react, `MAX_MS=20` -> after 20 ticks `done=1`, `timeout=1`, `time_ms=20`. Further ticks leave `time_ms=20`.
- React edge and `tick_ms` in the same cycle, with `time_ms=4` in ARMED -> `done=1`, `time_ms=4`, not 5.
- `DELAY_BASE=0`, `random=0` -> `led` rises two cycles after start edge with no tick required. Start edge while ARMED is ignored: `time_ms` keeps counting.
- Reset pulsed mid-ARMED with `time_ms=7` -> all outputs 0 asynchronously, state IDLE. Start held high through reset release -> no WAIT entry.

Source files
------------

// File: rtl/rt_pkg.sv
// Shared definitions for the reaction-timer control path and its display stage.
// State encoding, default timing limits and the delay-counter width helper.
package rt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_ARMED = 3'd2,
    ST_DONE  = 3'd3,
    ST_EARLY = 3'd4
  } state_e;

  localparam int DELAY_BASE_DEF = 1000;
  localparam int MAX_MS_DEF     = 9999;

  // Width needed to hold DELAY_BASE plus the largest N-bit random value.
  function automatic int dly_width(input int base, input int n);
    int w;
    w = $clog2(base + (1 << n));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rise_det.sv
// Registered rising-edge detector with a configurable history reset value.
// A level rising in cycle t yields a one-cycle edge pulse in cycle t+1.
module rise_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic level_i,
  output logic edge_o
);

  logic prev_q;
  logic edge_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= RST_VAL;
      edge_q <= 1'b0;
    end else begin
      prev_q <= level_i;
      edge_q <= level_i & ~prev_q;
    end
  end

  assign edge_o = edge_q;

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-timer controller: random pre-delay, stimulus LED, reaction count.
// state | meaning: IDLE idle, WAIT random delay, ARMED led on / counting, DONE result, EARLY false start.
module reaction_ctrl
  import rt_pkg::*;
#(
  parameter int N          = 12,
  parameter int DELAY_BASE = DELAY_BASE_DEF,
  parameter int MAX_MS     = MAX_MS_DEF,
  parameter int CW         = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick_ms,
  input  logic [N-1:0]  random,
  input  logic          start,
  input  logic          react,
  output logic          led,
  output logic [CW-1:0] time_ms,
  output logic          done,
  output logic          too_early,
  output logic          timeout,
  output logic          busy
);

  localparam int DW = dly_width(DELAY_BASE, N);

  logic start_edge;
  logic react_edge;

  state_e        state_q, state_d;
  logic [DW-1:0] dly_q, dly_d;
  logic [CW-1:0] time_q, time_d;
  logic          timeout_q, timeout_d;
  logic          led_q, done_q, early_q, busy_q;

  rise_det #(.RST_VAL(1'b1)) u_start_det (
    .clk     (clk),
    .reset   (reset),
    .level_i (start),
    .edge_o  (start_edge)
  );

  rise_det #(.RST_VAL(1'b1)) u_react_det (
    .clk     (clk),
    .reset   (reset),
    .level_i (react),
    .edge_o  (react_edge)
  );

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    time_d    = time_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_EARLY: begin
        if (start_edge) begin
          state_d   = ST_WAIT;
          dly_d     = DW'(DELAY_BASE) + DW'(random);
          time_d    = '0;
          timeout_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (react_edge) begin
          state_d = ST_EARLY;
        end else if (dly_q == '0) begin
          state_d = ST_ARMED;
          time_d  = '0;
        end else if (tick_ms) begin
          dly_d = dly_q - DW'(1);
          if (dly_q == DW'(1)) begin
            state_d = ST_ARMED;
            time_d  = '0;
          end
        end
      end
      ST_ARMED: begin
        // A react edge wins over a same-cycle tick, so that tick is not counted.
        if (react_edge) begin
          state_d = ST_DONE;
        end else if (tick_ms) begin
          time_d = time_q + CW'(1);
          if (time_d >= CW'(MAX_MS)) begin
            time_d    = CW'(MAX_MS);
            state_d   = ST_DONE;
            timeout_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      dly_q     <= '0;
      time_q    <= '0;
      timeout_q <= 1'b0;
      led_q     <= 1'b0;
      done_q    <= 1'b0;
      early_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      time_q    <= time_d;
      timeout_q <= timeout_d;
      led_q     <= (state_d == ST_ARMED);
      done_q    <= (state_d == ST_DONE);
      early_q   <= (state_d == ST_EARLY);
      busy_q    <= (state_d == ST_WAIT) || (state_d == ST_ARMED);
    end
  end

  assign led       = led_q;
  assign time_ms   = time_q;
  assign done      = done_q;
  assign too_early = early_q;
  assign timeout   = timeout_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed bench for reaction_ctrl: one instance with a 2-tick base delay,
// one with zero base delay, both with a 20 ms saturation limit.
module tb_reaction_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] random = '0;
  logic        tick_ms = 1'b0, start = 1'b0, react = 1'b0;
  logic        tick0 = 1'b0, start0 = 1'b0, react0 = 1'b0;

  logic        led, done, too_early, timeout, busy;
  logic [13:0] time_ms;
  logic        led0, done0, too_early0, timeout0, busy0;
  logic [13:0] time0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reaction_ctrl #(.N(12), .DELAY_BASE(2), .MAX_MS(20), .CW(14)) u_dut (
    .clk(clk), .reset(reset), .tick_ms(tick_ms), .random(random),
    .start(start), .react(react), .led(led), .time_ms(time_ms),
    .done(done), .too_early(too_early), .timeout(timeout), .busy(busy)
  );

  reaction_ctrl #(.N(12), .DELAY_BASE(0), .MAX_MS(20), .CW(14)) u_dut0 (
    .clk(clk), .reset(reset), .tick_ms(tick0), .random(random),
    .start(start0), .react(react0), .led(led0), .time_ms(time0),
    .done(done0), .too_early(too_early0), .timeout(timeout0), .busy(busy0)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tick_a(input int n);
    repeat (n) begin
      tick_ms = 1'b1; @(negedge clk);
      tick_ms = 1'b0; @(negedge clk);
    end
  endtask

  task automatic tick_b(input int n);
    repeat (n) begin
      tick0 = 1'b1; @(negedge clk);
      tick0 = 1'b0; @(negedge clk);
    end
  endtask

  task automatic press_start_a();
    start = 1'b1; cyc(2); start = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({led, done, too_early, timeout, busy} !== 5'b0 || time_ms !== 14'd0) begin
      failures++;
      $display("FAIL reset_outputs: got led=%b done=%b early=%b to=%b busy=%b t=%0d, want all 0",
               led, done, too_early, timeout, busy, time_ms);
    end
    @(negedge clk); reset = 1'b1; cyc(2);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_basic();
    random = 12'd5;
    start = 1'b1; @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL busy_latency_early: busy=%b want 0", busy); end
    @(negedge clk); start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL busy_after_start: busy=%b want 1", busy); end
    tick_a(6);
    checks++;
    if (led !== 1'b0) begin failures++; $display("FAIL led_after_6_ticks: led=%b want 0", led); end
    tick_a(1);
    checks++;
    if (led !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL led_after_7_ticks: led=%b busy=%b want 1 1", led, busy);
    end
    tick_a(3);
    checks++;
    if (time_ms !== 14'd3) begin failures++; $display("FAIL armed_count: time_ms=%0d want 3", time_ms); end
    react = 1'b1; @(negedge clk);
    checks++;
    if (led !== 1'b1) begin failures++; $display("FAIL react_edge_latency: led=%b want 1", led); end
    @(negedge clk); react = 1'b0;
    checks++;
    if (done !== 1'b1 || time_ms !== 14'd3 || led !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL react_result: done=%b t=%0d led=%b busy=%b to=%b want 1 3 0 0 0",
               done, time_ms, led, busy, timeout);
    end
    tick_a(2);
    checks++;
    if (done !== 1'b1 || time_ms !== 14'd3) begin
      failures++; $display("FAIL done_hold: done=%b t=%0d want 1 3", done, time_ms);
    end
  endtask

  task automatic test_early();
    press_start_a();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || time_ms !== 14'd0) begin
      failures++; $display("FAIL restart_clear: busy=%b done=%b t=%0d want 1 0 0", busy, done, time_ms);
    end
    tick_a(2);
    react = 1'b1; cyc(2); react = 1'b0;
    checks++;
    if (too_early !== 1'b1 || busy !== 1'b0 || led !== 1'b0) begin
      failures++; $display("FAIL early_flag: early=%b busy=%b led=%b want 1 0 0", too_early, busy, led);
    end
    tick_a(8);
    checks++;
    if (led !== 1'b0 || too_early !== 1'b1) begin
      failures++; $display("FAIL early_hold: led=%b early=%b want 0 1", led, too_early);
    end
    press_start_a();
    checks++;
    if (too_early !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL early_restart: early=%b busy=%b want 0 1", too_early, busy);
    end
  endtask

  task automatic test_timeout();
    tick_a(7);
    checks++;
    if (led !== 1'b1) begin failures++; $display("FAIL timeout_armed: led=%b want 1", led); end
    tick_a(19);
    checks++;
    if (time_ms !== 14'd19 || done !== 1'b0) begin
      failures++; $display("FAIL timeout_pre: t=%0d done=%b want 19 0", time_ms, done);
    end
    tick_a(1);
    checks++;
    if (done !== 1'b1 || timeout !== 1'b1 || time_ms !== 14'd20 || led !== 1'b0) begin
      failures++;
      $display("FAIL timeout_hit: done=%b to=%b t=%0d led=%b want 1 1 20 0", done, timeout, time_ms, led);
    end
    tick_a(3);
    checks++;
    if (time_ms !== 14'd20 || timeout !== 1'b1) begin
      failures++; $display("FAIL timeout_saturate: t=%0d to=%b want 20 1", time_ms, timeout);
    end
  endtask

  task automatic test_same_cycle();
    press_start_a();
    checks++;
    if (timeout !== 1'b0 || done !== 1'b0) begin
      failures++; $display("FAIL timeout_clear: to=%b done=%b want 0 0", timeout, done);
    end
    tick_a(7);
    tick_a(4);
    checks++;
    if (time_ms !== 14'd4) begin failures++; $display("FAIL same_cycle_pre: t=%0d want 4", time_ms); end
    react = 1'b1; @(negedge clk);
    tick_ms = 1'b1; @(negedge clk);
    tick_ms = 1'b0; react = 1'b0;
    checks++;
    if (done !== 1'b1 || time_ms !== 14'd4) begin
      failures++; $display("FAIL react_wins_tick: done=%b t=%0d want 1 4", done, time_ms);
    end
  endtask

  task automatic test_zero_delay();
    random = 12'd0;
    start0 = 1'b1; @(negedge clk);
    checks++;
    if (busy0 !== 1'b0) begin failures++; $display("FAIL zero_busy_early: busy=%b want 0", busy0); end
    @(negedge clk); start0 = 1'b0;
    checks++;
    if (busy0 !== 1'b1 || led0 !== 1'b0) begin
      failures++; $display("FAIL zero_wait: busy=%b led=%b want 1 0", busy0, led0);
    end
    @(negedge clk);
    checks++;
    if (led0 !== 1'b1) begin failures++; $display("FAIL zero_led: led=%b want 1", led0); end
    tick_b(2);
    checks++;
    if (time0 !== 14'd2) begin failures++; $display("FAIL zero_count: t=%0d want 2", time0); end
    start0 = 1'b1; cyc(2); start0 = 1'b0; cyc(1);
    checks++;
    if (busy0 !== 1'b1 || led0 !== 1'b1 || done0 !== 1'b0 || time0 !== 14'd2) begin
      failures++;
      $display("FAIL start_ignored_armed: busy=%b led=%b done=%b t=%0d want 1 1 0 2", busy0, led0, done0, time0);
    end
    tick_b(5);
    checks++;
    if (time0 !== 14'd7) begin failures++; $display("FAIL armed_keeps_counting: t=%0d want 7", time0); end
  endtask

  task automatic test_reset_mid();
    start0 = 1'b1; start = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({led0, done0, too_early0, timeout0, busy0} !== 5'b0 || time0 !== 14'd0) begin
      failures++;
      $display("FAIL async_reset_mid: led=%b done=%b early=%b to=%b busy=%b t=%0d want all 0",
               led0, done0, too_early0, timeout0, busy0, time0);
    end
    checks++;
    if (done !== 1'b0 || time_ms !== 14'd0) begin
      failures++; $display("FAIL async_reset_other: done=%b t=%0d want 0 0", done, time_ms);
    end
    @(negedge clk); reset = 1'b1;
    cyc(4);
    checks++;
    if (busy0 !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL held_start_no_edge: busy0=%b busy=%b want 0 0", busy0, busy);
    end
    start0 = 1'b0; start = 1'b0; @(negedge clk);
    start0 = 1'b1; cyc(2); start0 = 1'b0;
    checks++;
    if (busy0 !== 1'b1) begin failures++; $display("FAIL start_after_reset: busy=%b want 1", busy0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_early();
    test_timeout();
    test_same_cycle();
    test_zero_delay();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
